// File: rtl/phase_sequencer_if.sv
// Signal bundle between phase_sequencer and the decoder, PC, register file and memory port.
interface phase_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic [15:0]      COMMAND;
    logic             write;
    logic             writeEnable;
    logic             PC_load;
    logic             branch_taken;
    logic             mem_ready;
    logic             step;

    logic [4:0]       phase;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_load_en;
    logic             reg_we;
    logic             mem_req;
    logic             mem_we;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, COMMAND, write, writeEnable, PC_load, branch_taken, mem_ready, step,
        output phase, ir_load, pc_inc, pc_load_en, reg_we, mem_req, mem_we, halted,
               instr_count
    );

    modport slave (
        output run, COMMAND, write, writeEnable, PC_load, branch_taken, mem_ready, step,
        input  phase, ir_load, pc_inc, pc_load_en, reg_we, mem_req, mem_we, halted,
               instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer gating decoder strobes into fetch/read/execute/memory/writeback.
// Optional single-step mode (STEP_WAIT after every writeback) is enabled by defining SEQ_STEP_EN.
module phase_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    phase_sequencer_if.master bus
);
    localparam int unsigned PH_W = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1        = 3'd1,
        P2        = 3'd2,
        P3        = 3'd3,
        P4        = 3'd4,
        P5        = 3'd5,
        HALT      = 3'd6
`ifdef SEQ_STEP_EN
        , STEP_WAIT = 3'd7
`endif
    } state_t;

    state_t            state;
    logic [PH_W-1:0]   phase_q;
    logic              halted_q;
    logic [CNT_W-1:0]  count;

    logic              is_load;
    logic              is_hlt;
    logic              mem_phase;
    state_t            after_wb;

    logic              ir_load_c;
    logic              pc_inc_c;
    logic              pc_load_en_c;
    logic              reg_we_c;
    logic              mem_req_c;
    logic              mem_we_c;

    // Instruction classes resolved from the opcode field.
    assign is_load   = (bus.COMMAND[15:14] == 2'b00);
    assign is_hlt    = (bus.COMMAND[15:14] == 2'b11) && (bus.COMMAND[7:4] == 4'hF);
    assign mem_phase = is_load | bus.writeEnable;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{bus.COMMAND[13:8], bus.COMMAND[3:0]};

`ifdef SEQ_STEP_EN
    assign after_wb = STEP_WAIT;
`else
    assign after_wb = P1;
    logic unused_step;
    assign unused_step = bus.step;
`endif

    function automatic logic [PH_W-1:0] phase_of(input state_t s);
        logic [PH_W-1:0] ph;
        ph = '0;
        case (s)
            P1:      ph = PH_W'(5'b00001);
            P2:      ph = PH_W'(5'b00010);
            P3:      ph = PH_W'(5'b00100);
            P4:      ph = PH_W'(5'b01000);
            P5:      ph = PH_W'(5'b10000);
            default: ph = '0;
        endcase
        return ph;
    endfunction

    // Phase FSM; phase and halted are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            phase_q  <= '0;
            halted_q <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state   <= P1;
                        phase_q <= phase_of(P1);
                    end
                end
                P1: begin
                    if (bus.mem_ready) begin
                        state   <= P2;
                        phase_q <= phase_of(P2);
                    end
                end
                P2: begin
                    state   <= P3;
                    phase_q <= phase_of(P3);
                end
                P3: begin
                    if (is_hlt) begin
                        state    <= HALT;
                        phase_q  <= '0;
                        halted_q <= 1'b1;
                    end else begin
                        state   <= P4;
                        phase_q <= phase_of(P4);
                    end
                end
                P4: begin
                    if (!mem_phase || bus.mem_ready) begin
                        state   <= P5;
                        phase_q <= phase_of(P5);
                    end
                end
                P5: begin
                    state   <= after_wb;
                    phase_q <= phase_of(after_wb);
                    count   <= count + CNT_W'(1);
                end
                HALT: begin
                    if (bus.run) begin
                        state    <= P1;
                        phase_q  <= phase_of(P1);
                        halted_q <= 1'b0;
                    end
                end
`ifdef SEQ_STEP_EN
                STEP_WAIT: begin
                    if (bus.step) begin
                        state   <= P1;
                        phase_q <= phase_of(P1);
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    phase_q  <= '0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobes follow the current phase and the same-cycle decoder/handshake inputs.
    always_comb begin
        ir_load_c    = 1'b0;
        pc_inc_c     = 1'b0;
        pc_load_en_c = 1'b0;
        reg_we_c     = 1'b0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        case (state)
            P1: begin
                mem_req_c = 1'b1;
                ir_load_c = bus.mem_ready;
            end
            P4: begin
                if (mem_phase) begin
                    mem_req_c = 1'b1;
                    mem_we_c  = bus.writeEnable;
                end
            end
            P5: begin
                reg_we_c = bus.write;
                if (bus.PC_load && bus.branch_taken) begin
                    pc_load_en_c = 1'b1;
                end else begin
                    pc_inc_c = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.phase       = phase_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count;
    assign bus.ir_load     = ir_load_c;
    assign bus.pc_inc      = pc_inc_c;
    assign bus.pc_load_en  = pc_load_en_c;
    assign bus.reg_we      = reg_we_c;
    assign bus.mem_req     = mem_req_c;
    assign bus.mem_we      = mem_we_c;

    a_pc_excl: assert property (@(posedge clk) disable iff (reset) !(pc_inc_c && pc_load_en_c));
    a_phase_1h: assert property (@(posedge clk) disable iff (reset) $onehot0(phase_q));
endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed instruction table, reset/wrap corner sequences and a
// randomized run checked cycle by cycle against a trace built from the phase rules.
module tb_phase_sequencer;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_W_S = 4;

    logic clk = 1'b0;
    logic reset;
    logic reset_w;
    always #5 clk = ~clk;

    phase_sequencer_if #(.CNT_W(CNT_W))   bus ();
    phase_sequencer_if #(.CNT_W(CNT_W_S)) bus_w ();

    phase_sequencer #(.CNT_W(CNT_W))   dut   (.clk(clk), .reset(reset),   .bus(bus));
    phase_sequencer #(.CNT_W(CNT_W_S)) dut_w (.clk(clk), .reset(reset_w), .bus(bus_w));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] enc(input logic [4:0] ph, input logic irl, input logic pci,
                                        input logic pld, input logic rwe, input logic mrq,
                                        input logic mwe, input logic hlt);
        return {ph, irl, pci, pld, rwe, mrq, mwe, hlt};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.phase, bus.ir_load, bus.pc_inc, bus.pc_load_en, bus.reg_we,
                bus.mem_req, bus.mem_we, bus.halted};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0] cmd;
        logic [3:0]  dec;   // {write, writeEnable, PC_load, branch_taken}
        int w1; int w4;
        int cyc; int irl; int inc; int pld; int rwe; int req; int mwe; int hlt; int dcnt;
    } vec_t;
    vec_t vt [12];

    task automatic run_vec(input int i);
        int n1, n4, cyc, irl, inc, pld, rwe, req, mwe, hlt;
        logic done;
        logic [CNT_W-1:0] cnt0;
        n1 = 0; n4 = 0; cyc = 0; irl = 0; inc = 0; pld = 0; rwe = 0; req = 0; mwe = 0; hlt = 0;
        done = 1'b0;
        bus.COMMAND = vt[i].cmd;
        {bus.write, bus.writeEnable, bus.PC_load, bus.branch_taken} = vt[i].dec;
        cnt0 = bus.instr_count;
        for (int c = 0; c < 60 && !done; c++) begin
            bus.run       = (bus.phase == 5'b0);
            bus.step      = (bus.phase == 5'b0);
            bus.mem_ready = 1'b0;
            if (bus.phase[0]) begin
                bus.mem_ready = (n1 == vt[i].w1);
                n1++;
            end
            if (bus.phase[3]) begin
                bus.mem_ready = (n4 == vt[i].w4);
                n4++;
            end
            @(negedge clk);
            if (bus.phase != 5'b0) cyc++;
            irl += int'(bus.ir_load);
            inc += int'(bus.pc_inc);
            pld += int'(bus.pc_load_en);
            rwe += int'(bus.reg_we);
            req += int'(bus.mem_req);
            mwe += int'(bus.mem_we);
            if (bus.halted) begin
                hlt  = 1;
                done = 1'b1;
            end
            if (bus.phase[4]) done = 1'b1;
            @(posedge clk); #1;
        end
        chk($sformatf("vec%0d_done", i), 32'(done), 32'(1));
        chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
        chk($sformatf("vec%0d_ir_load", i), 32'(irl), 32'(vt[i].irl));
        chk($sformatf("vec%0d_pc_inc", i), 32'(inc), 32'(vt[i].inc));
        chk($sformatf("vec%0d_pc_load_en", i), 32'(pld), 32'(vt[i].pld));
        chk($sformatf("vec%0d_reg_we", i), 32'(rwe), 32'(vt[i].rwe));
        chk($sformatf("vec%0d_mem_req", i), 32'(req), 32'(vt[i].req));
        chk($sformatf("vec%0d_mem_we", i), 32'(mwe), 32'(vt[i].mwe));
        chk($sformatf("vec%0d_halted", i), 32'(hlt), 32'(vt[i].hlt));
        chk($sformatf("vec%0d_count_delta", i), 32'(CNT_W'(bus.instr_count - cnt0)),
            32'(vt[i].dcnt));
    endtask

    // ---------------- randomized trace model ----------------
    typedef struct packed {
        logic        run;
        logic        step;
        logic        rdy;
        logic [15:0] cmd;
        logic [3:0]  dec;
        logic [11:0] out;
        logic [15:0] cnt;
    } cyc_t;
    cyc_t        plan [$];
    logic [15:0] mcnt;
    logic [15:0] cur_cmd;
    logic [3:0]  cur_dec;

    task automatic push(input logic run, input logic step, input logic rdy, input logic [11:0] out);
        cyc_t e;
        e.run = run; e.step = step; e.rdy = rdy;
        e.cmd = cur_cmd; e.dec = cur_dec; e.out = out; e.cnt = mcnt;
        plan.push_back(e);
    endtask

    task automatic plan_instr();
        int kind, w1, w4, hn;
        logic [15:0] c;
        logic wr, we, pcl, bt, mem;
        kind = int'($urandom_range(4, 0));
        c    = 16'($urandom);
        wr = rb(); pcl = rb(); bt = rb(); we = 1'b0;
        case (kind)
            0:       c[15:14] = 2'b00;
            1:       we = 1'b1;
            4:       begin c[15:14] = 2'b11; c[7:4] = 4'hF; end
            default: if (c[15:14] == 2'b00) c[15:14] = 2'b01;
        endcase
        if (kind != 4 && c[15:14] == 2'b11 && c[7:4] == 4'hF) c[4] = 1'b0;
        mem = (c[15:14] == 2'b00) || we;
        w1 = int'($urandom_range(3, 0));
        w4 = int'($urandom_range(3, 0));
        cur_cmd = c;
        cur_dec = {wr, we, pcl, bt};
        for (int k = 0; k < w1; k++) push(rb(), rb(), 1'b0, enc(5'b00001, 0, 0, 0, 0, 1, 0, 0));
        push(rb(), rb(), 1'b1, enc(5'b00001, 1, 0, 0, 0, 1, 0, 0));
        push(rb(), rb(), rb(), enc(5'b00010, 0, 0, 0, 0, 0, 0, 0));
        push(rb(), rb(), rb(), enc(5'b00100, 0, 0, 0, 0, 0, 0, 0));
        if (kind == 4) begin
            hn = int'($urandom_range(2, 0));
            for (int k = 0; k < hn; k++) push(1'b0, rb(), rb(), enc(5'b0, 0, 0, 0, 0, 0, 0, 1));
            push(1'b1, rb(), rb(), enc(5'b0, 0, 0, 0, 0, 0, 0, 1));
            return;
        end
        if (mem) begin
            for (int k = 0; k < w4; k++) push(rb(), rb(), 1'b0, enc(5'b01000, 0, 0, 0, 0, 1, we, 0));
            push(rb(), rb(), 1'b1, enc(5'b01000, 0, 0, 0, 0, 1, we, 0));
        end else begin
            push(rb(), rb(), rb(), enc(5'b01000, 0, 0, 0, 0, 0, 0, 0));
        end
        push(rb(), rb(), rb(), enc(5'b10000, 0, !(pcl && bt), pcl && bt, wr, 0, 0, 0));
        mcnt = mcnt + 16'd1;
`ifdef SEQ_STEP_EN
        hn = int'($urandom_range(2, 0));
        for (int k = 0; k < hn; k++) push(rb(), 1'b0, rb(), 12'h000);
        push(rb(), 1'b1, rb(), 12'h000);
`endif
    endtask

    task automatic run_plan();
        cyc_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            bus.run = e.run; bus.step = e.step; bus.mem_ready = e.rdy; bus.COMMAND = e.cmd;
            {bus.write, bus.writeEnable, bus.PC_load, bus.branch_taken} = e.dec;
            @(negedge clk);
            chk("rand_out", 32'(obs()), 32'(e.out));
            chk("rand_cnt", 32'(bus.instr_count), 32'(e.cnt));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic done;
        logic found;

        vt[0]  = '{16'h4123, 4'b1000, 0, 0, 5, 1, 1, 0, 1, 1, 0, 0, 1};
        vt[1]  = '{16'h0123, 4'b1000, 0, 3, 8, 1, 1, 0, 1, 5, 0, 0, 1};
        vt[2]  = '{16'h8456, 4'b0100, 2, 1, 8, 1, 1, 0, 0, 5, 2, 0, 1};
        vt[3]  = '{16'hB005, 4'b0011, 1, 2, 6, 1, 0, 1, 0, 2, 0, 0, 1};
        vt[4]  = '{16'hB005, 4'b0010, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 1};
        vt[5]  = '{16'h5000, 4'b1001, 0, 0, 5, 1, 1, 0, 1, 1, 0, 0, 1};
        vt[6]  = '{16'hC0F0, 4'b1011, 1, 0, 4, 1, 0, 0, 0, 2, 0, 1, 0};
        vt[7]  = '{16'h4001, 4'b1000, 0, 0, 5, 1, 1, 0, 1, 1, 0, 0, 1};
        vt[8]  = '{16'hC0E0, 4'b1000, 0, 0, 5, 1, 1, 0, 1, 1, 0, 0, 1};
        vt[9]  = '{16'h30F0, 4'b1000, 0, 0, 5, 1, 1, 0, 1, 2, 0, 0, 1};
        vt[10] = '{16'h0000, 4'b0100, 0, 2, 7, 1, 1, 0, 0, 4, 3, 0, 1};
        vt[11] = '{16'hFFFF, 4'b0100, 0, 0, 3, 1, 0, 0, 0, 1, 0, 1, 0};

        reset = 1'b1; reset_w = 1'b1;
        bus.run = 1'b1; bus.step = 1'b0; bus.mem_ready = 1'b0; bus.COMMAND = 16'h0;
        bus.write = 1'b0; bus.writeEnable = 1'b0; bus.PC_load = 1'b0; bus.branch_taken = 1'b0;
        bus_w.run = 1'b1; bus_w.step = 1'b1; bus_w.mem_ready = 1'b1; bus_w.COMMAND = 16'h4000;
        bus_w.write = 1'b1; bus_w.writeEnable = 1'b0; bus_w.PC_load = 1'b0;
        bus_w.branch_taken = 1'b0;

        // Reset held together with run: reset wins.
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_out", 32'(obs()), 32'(0));
        chk("reset_cnt", 32'(bus.instr_count), 32'(0));
        chk("reset_cnt_w", 32'(bus_w.instr_count), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0; reset_w = 1'b0; bus.run = 1'b0;
        @(negedge clk);
        chk("idle_hold", 32'(obs()), 32'(0));
        @(posedge clk); #1;

        // Counter wrap on a narrow instance running back-to-back instructions.
        k = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (bus_w.phase[4]) begin
                chk("wrap_pre", 32'(bus_w.instr_count), 32'(k));
                k++;
                if (k == 16) done = 1'b1;
            end
        end
        chk("wrap_p5_seen", 32'(k), 32'(16));
        @(posedge clk); #1;
        chk("wrap_zero", 32'(bus_w.instr_count), 32'(0));
        reset_w = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i);

        // Reset while a load is waiting in the memory phase.
        bus.COMMAND = 16'h0042; {bus.write, bus.writeEnable, bus.PC_load, bus.branch_taken} = 4'b1000;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (bus.phase[3]) begin
                found = 1'b1;
            end else begin
                bus.run = (bus.phase == 5'b0); bus.step = (bus.phase == 5'b0);
                bus.mem_ready = bus.phase[0];
                @(posedge clk); #1;
            end
        end
        chk("p4_reached", 32'(found), 32'(1));
        bus.run = 1'b0; bus.step = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("p4_req", 32'({bus.mem_req, bus.mem_we}), 32'(2'b10));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_p4_out", 32'(obs()), 32'(0));
        chk("rst_p4_cnt", 32'(bus.instr_count), 32'(0));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus.mem_ready = ~bus.mem_ready;
            @(negedge clk);
            chk("post_rst_idle", 32'(obs()), 32'(0));
        end
        @(posedge clk); #1;

        // Randomized instruction stream from IDLE.
        mcnt = 16'd0; cur_cmd = 16'h0; cur_dec = 4'b0;
        push(1'b0, rb(), rb(), 12'h000);
        push(1'b0, rb(), rb(), 12'h000);
        push(1'b1, rb(), rb(), 12'h000);
        for (int n = 0; n < 80; n++) plan_instr();
        run_plan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
